pong_paddle_bank: RTL
=====================

# pong_paddle_bank

Parametrised multi-channel paddle controller for the pong engine. It replaces per-paddle hand-written quadrature logic with one bank of NUM_PADDLES channels. Each channel has an input synchroniser, a full-state quadrature decoder with illegal-transition detection, a clamped paddle position register, and a frame-paced autopilot that tracks a target Y. It sits between the encoder pins and the renderer/collision logic, which consume `paddle_y` directly as the paddle centre line.

## Interface
- NUM_PADDLES, 2, number of independent paddle channels
- YW, 11, width of one Y coordinate (matches the VGA counters)
- SHEIGHT, 480, active screen height in lines
- PADDLE_HEIGHT, 25, paddle half-height; the paddle spans y-PADDLE_HEIGHT..y+PADDLE_HEIGHT
- PADDLE_SPEED, 8, lines moved per valid encoder transition
- AUTO_SPEED, 1, maximum lines moved per frame_tick in autopilot
- Y_INIT, 236, reset position; clamped into the legal range
- ACCEL_WINDOW, 1000, cycles; used only with PADDLE_ACCEL_EN

Ports:
- clk  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-high reset
- quad_a  in  NUM_PADDLES  encoder A phase per channel; asynchronous
- quad_b  in  NUM_PADDLES  encoder B phase per channel; asynchronous
- autopilot  in  NUM_PADDLES  1 = channel follows target_y, encoder ignored for motion
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- target_y  in  YW  autopilot target centre (ball Y), shared by all channels
- paddle_y  out  NUM_PADDLES*YW  packed centre positions; channel i at [i*YW +: YW]
- step_pulse  out  NUM_PADDLES  one-cycle pulse per valid decoded transition (speaker/LED use)
- err  out  NUM_PADDLES  sticky flag: an illegal quadrature transition was seen

## Operation
- Legal range: YMIN = PADDLE_HEIGHT, YMAX = SHEIGHT-1-PADDLE_HEIGHT (25..454 by default).
- Every position update saturates into [YMIN, YMAX]. An update that would overshoot lands exactly on the bound; it is never skipped.
- Synchroniser, per channel: {a,b} passes through two flops s1 and s2. History h <= s2 every cycle.
- Decoder compares h to s2:
  - Gray sequence 00→01→11→10→00 = +1 (down, y increases).
  - Reverse sequence = −1.
  - Equal = no event.
  - Both bits changed = illegal: set err[i], no move, no step_pulse.
- Priming: a 2-bit counter blocks all decode events for the first 3 cycles after reset deasserts. During that window h and s fill with live inputs, so no spurious step occurs.
- Manual mode (autopilot[i]=0): each valid event moves y by ±PADDLE_SPEED (with clamp) and pulses step_pulse[i]. The pulse fires even when clamped at a bound.
- Autopilot mode (autopilot[i]=1): on frame_tick, d = target_y − y.
  - d > 0: y += min(d, AUTO_SPEED).
  - d < 0: y −= min(|d|, AUTO_SPEED).
  - d = 0: hold.
  - Clamp applies in all cases.
  - Encoder events still drive step_pulse and err, but never move y.
- frame_tick with autopilot[i]=0 is ignored. Only one update source is active per channel, so events never collide.
- autopilot changes take effect on the next clock edge. Position is preserved across mode switches.
- Arithmetic is done in YW+1 bits signed, then clamped. target_y values ≥ SHEIGHT clamp to YMAX.

## Timing
- Reset (asynchronous): paddle_y = clamp(Y_INIT), step_pulse = 0, err = 0, s1/s2/h = 0, prime counter = 0, accel state cleared.
- Input latency: a change on quad_a/b before edge n updates paddle_y and step_pulse at edge n+2 (s1 at n, s2 at n+1, compare and register at n+2). Visible after edge n+2.
- Autopilot: paddle_y updates at the edge following the cycle in which frame_tick is high.
- step_pulse is exactly 1 cycle wide. Back-to-back legal transitions on consecutive cycles each produce a pulse and a move.
- err stays 1 until reset.
- Reset asserted mid-operation aborts any update immediately. Re-priming follows deassertion.

## Configuration
- PADDLE_ACCEL_EN defined: each channel keeps a last-direction bit and a gap counter. The counter saturates at ACCEL_WINDOW and clears on each valid event.
  - A valid event with the same direction as the previous one and gap < ACCEL_WINDOW moves 2*PADDLE_SPEED.
  - Any other valid event moves PADDLE_SPEED.
  - Accel state clears on reset and while autopilot[i]=1.
- PADDLE_ACCEL_EN undefined: constant PADDLE_SPEED. No counter is built, and ACCEL_WINDOW is unused.

## Test plan
- Reset release with quad_a=quad_b=2'b11 → paddle_y = 236 on both channels; no step_pulse and no err in the following 10 cycles.
- Channel 0 driven 00→01→11→10, one change every 100 cycles, no accel → paddle_y0 = 244, 252, 260, each 2 edges after the input change; channel 1 stays 236.
- Drive channel 0 forward from 452 → 454; three more forward steps → holds 454 with 3 step_pulses; one reverse step → 446.
- Channel 1 jumps 00→11 → err[1]=1, paddle_y1 unchanged, no step_pulse; err[1] stays 1 through later legal steps until reset.
- Channel 1 autopilot=1, target_y=100, AUTO_SPEED=1, from 236 → reaches 100 after exactly 136 frame_ticks, then holds; target_y=0 → stops at 25; encoder toggling meanwhile does not move it.
- With PADDLE_ACCEL_EN and ACCEL_WINDOW=1000: forward steps 500 cycles apart → +8 then +16; a next step 2000 cycles later → +8; a reverse step within the window → −8.

Source files
------------

// File: rtl/pong_paddle_bank.sv
// ============================================================================
// Module   : pong_paddle_bank
// Bank of quadrature paddle channels: sync, decode, clamped Y, frame autopilot.
// Optional : PADDLE_ACCEL_EN adds same-direction step acceleration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pong_paddle_bank #(
   parameter int NUM_PADDLES   = 2,
   parameter int YW            = 11,
   parameter int SHEIGHT       = 480,
   parameter int PADDLE_HEIGHT = 25,
   parameter int PADDLE_SPEED  = 8,
   parameter int AUTO_SPEED    = 1,
   parameter int Y_INIT        = 236,
   parameter int ACCEL_WINDOW  = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PADDLES-1:0]    quad_a,
   input  logic [NUM_PADDLES-1:0]    quad_b,
   input  logic [NUM_PADDLES-1:0]    autopilot,
   input  logic                      frame_tick,
   input  logic [YW-1:0]             target_y,
   output logic [NUM_PADDLES*YW-1:0] paddle_y,
   output logic [NUM_PADDLES-1:0]    step_pulse,
   output logic [NUM_PADDLES-1:0]    err
);

   localparam int C_YMIN = PADDLE_HEIGHT;
   localparam int C_YMAX = SHEIGHT - 1 - PADDLE_HEIGHT;
   localparam int C_YRST = (Y_INIT < C_YMIN) ? C_YMIN :
                           (Y_INIT > C_YMAX) ? C_YMAX : Y_INIT;

   localparam logic signed [YW:0] C_YMIN_S   = (YW+1)'(C_YMIN);
   localparam logic signed [YW:0] C_YMAX_S   = (YW+1)'(C_YMAX);
   localparam logic signed [YW:0] C_SPEED_S  = (YW+1)'(PADDLE_SPEED);
   localparam logic signed [YW:0] C_AUTO_S   = (YW+1)'(AUTO_SPEED);
   localparam logic [YW-1:0]      C_YRST_U   = YW'(C_YRST);

   function automatic logic [YW-1:0] clamp_y(input logic signed [YW:0] v);
      logic signed [YW:0] r;
      if (v < C_YMIN_S)
         r = C_YMIN_S;
      else if (v > C_YMAX_S)
         r = C_YMAX_S;
      else
         r = v;
      return r[YW-1:0];
   endfunction

   // Position of a phase pair along the forward Gray cycle 00,01,11,10.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         2'b00:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         2'b11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   logic [1:0] prime_q;
   logic [1:0] prime_d;
   logic       w_primed;

   always_comb begin
      prime_d = prime_q;
      if (prime_q != 2'd3)
         prime_d = prime_q + 2'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prime_q <= 2'd0;
      else
         prime_q <= prime_d;
   end

   assign w_primed = (prime_q == 2'd3);

   for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
      logic [1:0]         s1_q, s2_q, h_q;
      logic [YW-1:0]      y_q, y_d;
      logic               step_q, step_d;
      logic               err_q, err_d;
      logic [1:0]         w_hidx, w_sidx;
      logic               w_fwd, w_rev, w_ill;
      logic signed [YW:0] w_y_s, w_tgt_s, w_diff, w_mstep, w_sum;

      assign w_hidx = gray_idx(h_q);
      assign w_sidx = gray_idx(s2_q);
      assign w_ill  = w_primed & ((h_q ^ s2_q) == 2'b11);
      assign w_fwd  = w_primed & (w_sidx == w_hidx + 2'd1);
      assign w_rev  = w_primed & (w_hidx == w_sidx + 2'd1);

`ifdef PADDLE_ACCEL_EN
      localparam int GW = $clog2(ACCEL_WINDOW + 1);
      localparam logic [GW-1:0]      C_WIN_G    = GW'(ACCEL_WINDOW);
      localparam logic signed [YW:0] C_SPEED2_S = (YW+1)'(2 * PADDLE_SPEED);

      logic [GW-1:0] gap_q, gap_d;
      logic          dir_q, dir_d;
      logic          w_accel;

      // A saturated gap means "no recent event", so the first step after
      // reset or autopilot is never accelerated regardless of dir_q.
      always_comb begin
         gap_d = gap_q;
         dir_d = dir_q;
         if (autopilot[i]) begin
            gap_d = C_WIN_G;
            dir_d = 1'b0;
         end else if (w_fwd | w_rev) begin
            gap_d = '0;
            dir_d = w_fwd;
         end else if (gap_q != C_WIN_G) begin
            gap_d = gap_q + GW'(1);
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            gap_q <= C_WIN_G;
            dir_q <= 1'b0;
         end else begin
            gap_q <= gap_d;
            dir_q <= dir_d;
         end
      end

      assign w_accel = (w_fwd | w_rev) & (dir_q == w_fwd) & (gap_q < C_WIN_G);
      assign w_mstep = w_accel ? C_SPEED2_S : C_SPEED_S;
`else
      logic [31:0] w_unused_accel_window;
      assign w_unused_accel_window = ACCEL_WINDOW;
      assign w_mstep = C_SPEED_S;
`endif

      assign w_y_s   = $signed({1'b0, y_q});
      assign w_tgt_s = $signed({1'b0, target_y});
      assign w_diff  = w_tgt_s - w_y_s;

      always_comb begin
         y_d    = y_q;
         step_d = w_fwd | w_rev;
         err_d  = err_q | w_ill;
         w_sum  = w_y_s;
         if (autopilot[i]) begin
            if (frame_tick) begin
               if (w_diff > C_AUTO_S)
                  w_sum = w_y_s + C_AUTO_S;
               else if (w_diff < -C_AUTO_S)
                  w_sum = w_y_s - C_AUTO_S;
               else
                  w_sum = w_tgt_s;
               y_d = clamp_y(w_sum);
            end
         end else if (w_fwd) begin
            w_sum = w_y_s + w_mstep;
            y_d   = clamp_y(w_sum);
         end else if (w_rev) begin
            w_sum = w_y_s - w_mstep;
            y_d   = clamp_y(w_sum);
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1_q   <= 2'b00;
            s2_q   <= 2'b00;
            h_q    <= 2'b00;
            y_q    <= C_YRST_U;
            step_q <= 1'b0;
            err_q  <= 1'b0;
         end else begin
            s1_q   <= {quad_a[i], quad_b[i]};
            s2_q   <= s1_q;
            h_q    <= s2_q;
            y_q    <= y_d;
            step_q <= step_d;
            err_q  <= err_d;
         end
      end

      assign paddle_y[i*YW +: YW] = y_q;
      assign step_pulse[i]        = step_q;
      assign err[i]               = err_q;
   end

endmodule

`default_nettype wire
